ifetch_unit: RTL

Instruction-fetch requester that drives the instruction memory's read port (address, read-enable) and captures the returned word. Maintains the fetch PC and a small prefetch FIFO of {instr, pc} entries. Presents them to decode through a valid/ready handshake. Handles branch/jump redirects and HALT detection, stopping fetch after a HALT.

---
 rtl/ifetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit
// Instruction-fetch requester. It drives the instruction memory read port,
// captures each returned word together with the PC it was fetched from into a
// small prefetch FIFO, and hands the FIFO head to decode.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   im_addr        word address to instruction memory (the fetch PC)
//   im_rd_en       read request; im_instr is captured on the following edge
//   im_instr       read data returned late in the request cycle
//   redirect       flush the FIFO and restart fetch at redirect_pc
//   redirect_pc    restart address
//   out_valid      FIFO head holds a valid entry
//   out_ready      decode accepts the head this cycle
//   out_instr      head instruction (0 when the FIFO is empty)
//   out_pc         head PC (0 when the FIFO is empty)
//   out_pc_plus1   head PC + 1, wrapping (0 when the FIFO is empty)
//   halted         a HALT was fetched and every entry has been delivered
//
// Handshake: an entry transfers to decode on a rising edge where both
// out_valid and out_ready are high. While out_valid is high and out_ready is
// low, the head entry is held unchanged.
module ifetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          DEPTH       = 2,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_instr,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic [15:0] out_pc_plus1,
    output logic        halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        FETCH   = 1'b0,
        STOPPED = 1'b1
    } state_t;

    state_t        state;
    logic [15:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [15:0]   instr_mem [DEPTH];
    logic [15:0]   pc_mem    [DEPTH];
    logic          pop;
    logic          is_halt;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign im_addr   = fetch_pc;

    // A full FIFO may still fetch when decode frees a slot in the same cycle.
    assign im_rd_en  = (state == FETCH) & ~redirect & ~rst &
                       ((count < DEPTH_C) | pop);

    assign is_halt   = (im_instr[15:12] == HALT_OPCODE);

    assign out_instr    = out_valid ? instr_mem[head]       : 16'h0000;
    assign out_pc       = out_valid ? pc_mem[head]          : 16'h0000;
    assign out_pc_plus1 = out_valid ? pc_mem[head] + 16'd1  : 16'h0000;

    assign halted = (state == STOPPED) & (count == '0);

    // Control: fetch PC, FIFO pointers/occupancy and the fetch/stop FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect) begin
            // A pop taken this cycle is simply lost in the flush.
            state    <= FETCH;
            fetch_pc <= redirect_pc;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            if (im_rd_en) begin
                tail     <= tail + PW'(1);
                fetch_pc <= fetch_pc + 16'd1;
                if (is_halt) begin
                    state <= STOPPED;
                end
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({im_rd_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; im_rd_en already excludes reset and redirect cycles.
    always_ff @(posedge clk) begin
        if (im_rd_en) begin
            instr_mem[tail] <= im_instr;
            pc_mem[tail]    <= fetch_pc;
        end
    end

endmodule
